// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: one registered output stage with
// valid/ready handshakes and an optional prefix word (IMMX_PREFIX_EN).
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_valid      input entry valid
//   in_ready      entry can be accepted this cycle
//   imm           raw immediate field (IMM_W bits)
//   sel           extend mode
//   is_prefix     entry is a prefix word (ignored without IMMX_PREFIX_EN)
//   flush         drop any held prefix
//   out_valid     out holds a valid operand
//   out_ready     consumer accepts out this cycle
//   out           extended operand (DATA_W bits)
//   out_err       operand came from a reserved sel code
//   pfx_pending   a prefix is held, waiting for an operand
//   pfx_overwrite one-cycle pulse: a held prefix was replaced
//
// Build option: define IMMX_PREFIX_EN to enable the prefix register.
// Without it, prefix entries are treated as plain operands.

module imm_extend_pipe #(
   parameter int DATA_W = 16,
   parameter int IMM_W  = 9,
   parameter int PFX_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IMM_W-1:0]  imm,
   input  logic [2:0]        sel,
   input  logic              is_prefix,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out,
   output logic              out_err,
   output logic              pfx_pending,
   output logic              pfx_overwrite
);

   localparam int BW = PFX_W + 8;

   logic              accept;
   logic              pfx_entry;
   logic              use_pfx;
   logic [DATA_W-1:0] pfx_val;

   logic [DATA_W-1:0] sx_full;
   logic [DATA_W-1:0] sx8;
   logic [DATA_W-1:0] sx6;
   logic [DATA_W-1:0] zx_full;
   logic [DATA_W-1:0] zx8;
   logic [DATA_W-1:0] upper;

   logic [DATA_W-1:0] nxt_out;
   logic              nxt_err;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   assign sx_full = DATA_W'($signed(imm));
   assign sx8     = DATA_W'($signed(imm[7:0]));
   assign sx6     = DATA_W'($signed(imm[5:0]));
   assign zx_full = DATA_W'(imm);
   assign zx8     = DATA_W'(imm[7:0]);
   assign upper   = {imm[7:0], {(DATA_W-8){1'b0}}};

`ifdef IMMX_PREFIX_EN

   logic [PFX_W-1:0] pfx_q;
   logic [BW-1:0]    base;
   logic             base_zx;

   assign pfx_entry = is_prefix;

   // A flush in the same cycle makes the operand see no prefix.
   assign use_pfx = pfx_pending && !flush;

   assign base    = {pfx_q, imm[7:0]};
   assign base_zx = (sel == 3'b011) || (sel == 3'b100);
   assign pfx_val = base_zx ? DATA_W'(base)
                            : DATA_W'($signed(base));

   always_ff @(posedge clk) begin
      if (rst) begin
         pfx_q         <= '0;
         pfx_pending   <= 1'b0;
         pfx_overwrite <= 1'b0;
      end else begin
         pfx_overwrite <= 1'b0;
         if (flush) begin
            // Also drops a prefix arriving this cycle.
            pfx_q       <= '0;
            pfx_pending <= 1'b0;
         end else if (accept) begin
            if (is_prefix) begin
               pfx_q         <= imm[PFX_W-1:0];
               pfx_pending   <= 1'b1;
               pfx_overwrite <= pfx_pending;
            end else begin
               pfx_pending <= 1'b0;
            end
         end
      end
   end

`else

   logic unused_pfx;

   assign pfx_entry     = 1'b0;
   assign use_pfx       = 1'b0;
   assign pfx_val       = '0;
   assign pfx_pending   = 1'b0;
   assign pfx_overwrite = 1'b0;
   assign unused_pfx    = is_prefix ^ flush;

`endif

   always_comb begin
      nxt_out = '0;
      nxt_err = 1'b0;
      if (use_pfx) begin
         // Reserved codes still yield a signed operand here.
         nxt_out = pfx_val;
      end else begin
         case (sel)
            3'b000:  nxt_out = sx_full;
            3'b001:  nxt_out = sx8;
            3'b010:  nxt_out = sx6;
            3'b011:  nxt_out = zx_full;
            3'b100:  nxt_out = zx8;
            3'b101:  nxt_out = upper;
            default: nxt_err = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out       <= '0;
         out_err   <= 1'b0;
      end else if (accept && !pfx_entry) begin
         out_valid <= 1'b1;
         out       <= nxt_out;
         out_err   <= nxt_err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: arithmetic reference model
// with scoreboard, per-cycle compare, and literal spot checks.

module tb_imm_extend_pipe;

   localparam int DATA_W = 16;
   localparam int IMM_W  = 9;
   localparam int PFX_W  = 8;

`ifdef IMMX_PREFIX_EN
   localparam bit PFX_EN = 1'b1;
`else
   localparam bit PFX_EN = 1'b0;
`endif

   typedef struct {
      logic [DATA_W-1:0] v;
      logic              e;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [IMM_W-1:0]  imm;
   logic [2:0]        sel;
   logic              is_prefix;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out;
   logic              out_err;
   logic              pfx_pending;
   logic              pfx_overwrite;

   int n_chk = 0;
   int n_fail = 0;

   exp_t        sb[$];
   bit          m_pend;
   int unsigned m_pfx;
   bit          m_ovw;

   imm_extend_pipe #(
      .DATA_W(DATA_W),
      .IMM_W (IMM_W),
      .PFX_W (PFX_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .imm          (imm),
      .sel          (sel),
      .is_prefix    (is_prefix),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out          (out),
      .out_err      (out_err),
      .pfx_pending  (pfx_pending),
      .pfx_overwrite(pfx_overwrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Two's-complement sign extension of the low n bits of v.
   function automatic longint sxn(longint v, int n);
      longint m;
      m = longint'(1) << n;
      v = v & (m - 1);
      if (v >= m / 2) v = v - m;
      return v;
   endfunction

   function automatic exp_t expv(int unsigned iv, int sv,
                                 bit held, int unsigned pv);
      exp_t   r;
      longint x;
      longint b;
      r.e = 1'b0;
      x = 0;
      if (held) begin
         b = longint'(pv) * 256 + longint'(iv % 256);
         if (sv == 3 || sv == 4) x = b;
         else x = sxn(b, PFX_W + 8);
      end else begin
         case (sv)
            0: x = sxn(longint'(iv), IMM_W);
            1: x = sxn(longint'(iv), 8);
            2: x = sxn(longint'(iv), 6);
            3: x = longint'(iv);
            4: x = longint'(iv % 256);
            5: x = longint'(iv % 256) * (longint'(1) << (DATA_W - 8));
            default: begin
               x = 0;
               r.e = 1'b1;
            end
         endcase
      end
      r.v = x[DATA_W-1:0];
      return r;
   endfunction

   // Reference model, advanced once per rising edge.
   initial begin
      bit acc;
      bit pe;
      m_pend = 1'b0;
      m_pfx  = 0;
      m_ovw  = 1'b0;
      forever begin
         @(posedge clk);
         if (rst) begin
            sb.delete();
            m_pend = 1'b0;
            m_pfx  = 0;
            m_ovw  = 1'b0;
         end else begin
            acc = in_valid && (sb.size() == 0 || out_ready);
            pe  = PFX_EN && is_prefix;
            if (out_ready && sb.size() > 0) void'(sb.pop_front());
            if (acc && !pe)
               sb.push_back(expv(int'(imm), int'(sel),
                                 m_pend && !flush, m_pfx));
            m_ovw = 1'b0;
            if (flush) begin
               m_pend = 1'b0;
               m_pfx  = 0;
            end else if (acc && pe) begin
               m_ovw  = m_pend;
               m_pfx  = int'(imm) % (1 << PFX_W);
               m_pend = 1'b1;
            end else if (acc) begin
               m_pend = 1'b0;
            end
         end
      end
   end

   // Per-cycle compare against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
         chk("in_ready", 32'(in_ready),
             32'(sb.size() == 0 || out_ready));
         chk("pfx_pending", 32'(pfx_pending), 32'(m_pend));
         chk("pfx_overwrite", 32'(pfx_overwrite), 32'(m_ovw));
         if (sb.size() > 0) begin
            chk("out", 32'(out), 32'(sb[0].v));
            chk("out_err", 32'(out_err), 32'(sb[0].e));
         end
      end
   end

   task automatic drive(input bit v, input logic [IMM_W-1:0] i,
                        input logic [2:0] s, input bit p,
                        input bit f, input bit r);
      in_valid  = v;
      imm       = i;
      sel       = s;
      is_prefix = p;
      flush     = f;
      out_ready = r;
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      drive(1'b0, 9'h000, 3'd0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      imm       = '0;
      sel       = '0;
      is_prefix = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("rst out_valid", 32'(out_valid), 32'h0);
      chk("rst out", 32'(out), 32'h0);
      chk("rst out_err", 32'(out_err), 32'h0);
      chk("rst pfx_pending", 32'(pfx_pending), 32'h0);
      chk("rst pfx_overwrite", 32'(pfx_overwrite), 32'h0);
      rst = 1'b0;
      idle();

      // Plain extend modes
      drive(1'b1, 9'h1FF, 3'd0, 1'b0, 1'b0, 1'b1);
      chk("t1 sx9 valid", 32'(out_valid), 32'h1);
      chk("t1 sx9", 32'(out), 32'hFFFF);
      chk("t1 sx9 err", 32'(out_err), 32'h0);
      drive(1'b1, 9'h1FF, 3'd3, 1'b0, 1'b0, 1'b1);
      chk("t1 zx9", 32'(out), 32'h01FF);
      drive(1'b1, 9'h0A5, 3'd5, 1'b0, 1'b0, 1'b1);
      chk("t2 upper", 32'(out), 32'hA500);
      drive(1'b1, 9'h0A5, 3'd6, 1'b0, 1'b0, 1'b1);
      chk("t2 rsv out", 32'(out), 32'h0000);
      chk("t2 rsv err", 32'(out_err), 32'h1);
      drive(1'b1, 9'h1A5, 3'd1, 1'b0, 1'b0, 1'b1);
      chk("sx8", 32'(out), 32'hFFA5);
      chk("sx8 err", 32'(out_err), 32'h0);
      drive(1'b1, 9'h1A5, 3'd2, 1'b0, 1'b0, 1'b1);
      chk("sx6", 32'(out), 32'hFFE5);
      drive(1'b1, 9'h1A5, 3'd4, 1'b0, 1'b0, 1'b1);
      chk("zx8", 32'(out), 32'h00A5);
      drive(1'b1, 9'h1A5, 3'd7, 1'b0, 1'b0, 1'b1);
      idle();

      // Prefix then operand, signed and unsigned
      drive(1'b1, 9'h081, 3'd0, 1'b1, 1'b0, 1'b1);
      chk("t3 pend", 32'(pfx_pending), 32'(PFX_EN));
      drive(1'b1, 9'h034, 3'd0, 1'b0, 1'b0, 1'b1);
      chk("t3 sx", 32'(out), PFX_EN ? 32'h8134 : 32'h0034);
      chk("t3 pend clr", 32'(pfx_pending), 32'h0);
      drive(1'b1, 9'h081, 3'd0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 9'h034, 3'd4, 1'b0, 1'b0, 1'b1);
      chk("t3 zx", 32'(out), PFX_EN ? 32'h8134 : 32'h0034);

      // Overwritten prefix
      drive(1'b1, 9'h012, 3'd0, 1'b1, 1'b0, 1'b1);
      chk("t4 no ovw", 32'(pfx_overwrite), 32'h0);
      drive(1'b1, 9'h0FF, 3'd0, 1'b1, 1'b0, 1'b1);
      chk("t4 ovw", 32'(pfx_overwrite), 32'(PFX_EN));
      drive(1'b1, 9'h001, 3'd0, 1'b0, 1'b0, 1'b1);
      chk("t4 ovw end", 32'(pfx_overwrite), 32'h0);
      chk("t4 out", 32'(out), PFX_EN ? 32'hFF01 : 32'h0001);

      // Flush with operand, flush with prefix
      drive(1'b1, 9'h055, 3'd0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 9'h020, 3'd1, 1'b0, 1'b1, 1'b1);
      chk("t5 out", 32'(out), 32'h0020);
      chk("t5 pend", 32'(pfx_pending), 32'h0);
      drive(1'b1, 9'h033, 3'd0, 1'b1, 1'b1, 1'b1);
      chk("flush pfx drop", 32'(pfx_pending), 32'h0);
      drive(1'b1, 9'h0C0, 3'd0, 1'b0, 1'b0, 1'b1);
      chk("flush after", 32'(out), 32'h00C0);

      // Reserved sel with a prefix held
      drive(1'b1, 9'h07F, 3'd0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 9'h0FF, 3'd7, 1'b0, 1'b0, 1'b1);
      chk("pfx rsv out", 32'(out), PFX_EN ? 32'h7FFF : 32'h0000);
      chk("pfx rsv err", 32'(out_err), PFX_EN ? 32'h0 : 32'h1);
      idle();

      // Backpressure
      drive(1'b1, 9'h0AA, 3'd4, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 9'h155, 3'd0, 1'b0, 1'b0, 1'b0);
         chk("t6 hold out", 32'(out), 32'h00AA);
         chk("t6 hold valid", 32'(out_valid), 32'h1);
         chk("t6 in_ready", 32'(in_ready), 32'h0);
      end
      drive(1'b1, 9'h155, 3'd0, 1'b0, 1'b0, 1'b1);
      chk("t6 next", 32'(out), 32'hFF55);
      idle();
      chk("t6 no dup", 32'(out_valid), 32'h0);

      // Prefix offered while stalled must wait
      drive(1'b1, 9'h003, 3'd0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 9'h0C3, 3'd0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 9'h0C3, 3'd0, 1'b1, 1'b0, 1'b0);
      chk("stall pend", 32'(pfx_pending), 32'h0);
      drive(1'b1, 9'h0C3, 3'd0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 9'h012, 3'd3, 1'b0, 1'b0, 1'b1);
      chk("stall pfx out", 32'(out), PFX_EN ? 32'hC312 : 32'h0012);
      idle();

      // Reset mid-operation
      drive(1'b1, 9'h155, 3'd0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 9'h000, 3'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      drive(1'b1, 9'h044, 3'd0, 1'b1, 1'b0, 1'b0);
      chk("mid rst valid", 32'(out_valid), 32'h0);
      chk("mid rst out", 32'(out), 32'h0);
      rst = 1'b0;
      drive(1'b1, 9'h044, 3'd0, 1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      idle();
      chk("mid rst pend", 32'(pfx_pending), 32'h0);
      rst = 1'b0;
      drive(1'b1, 9'h012, 3'd0, 1'b0, 1'b0, 1'b1);
      chk("post rst out", 32'(out), 32'h0012);
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
